// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch / decode /
// execute / memory / writeback over a shared memory port, drives datapath
// mux selects and strobes, counts retired instructions and traps on illegal
// opcodes or a memory request that never completes.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [2:0]       imm_sel,
    output logic [1:0]       alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             reg_write,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // Last wait count before giving up; only meaningful when the timeout is enabled.
    localparam logic [31:0] WAIT_LIMIT = (MEM_TIMEOUT > 0) ? 32'(MEM_TIMEOUT - 1) : 32'd0;

    state_t      state;
    state_t      state_next;
    logic [6:0]  opcode;
    logic        retire;
    logic        set_trap;
    logic [1:0]  cause_next;
    logic [31:0] wait_cnt;
    logic        timeout;

    assign opcode = instr[6:0];

    // A missing mem_ready in the limit cycle ends the wait; a ready in that cycle still completes.
    assign timeout = (MEM_TIMEOUT > 0) && (wait_cnt == WAIT_LIMIT) && !mem_ready;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: is_legal = 1'b1;
            default:                                is_legal = 1'b0;
        endcase
    endfunction

    // Immediate format: 0=I, 1=S, 2=B, 3=U, 4=J (OP has no immediate, reports I).
    function automatic logic [2:0] decode_imm(input logic [6:0] op);
        case (op)
            OPC_STORE:          decode_imm = 3'd1;
            OPC_BRANCH:         decode_imm = 3'd2;
            OPC_LUI, OPC_AUIPC: decode_imm = 3'd3;
            OPC_JAL:            decode_imm = 3'd4;
            default:            decode_imm = 3'd0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Next-state logic, retire and trap-entry detection
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        set_trap   = 1'b0;
        cause_next = 2'd0;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    set_trap   = 1'b1;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (is_legal(opcode)) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_TRAP;
                    set_trap   = 1'b1;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_next = S_MEM;
                    OPC_BRANCH: begin
                        state_next = S_FETCH;
                        retire     = 1'b1;
                    end
                    OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC,
                    OPC_JAL, OPC_JALR:   state_next = S_WB;
                    default: begin
                        state_next = S_TRAP;
                        set_trap   = 1'b1;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OPC_STORE) begin
                        state_next = S_FETCH;
                        retire     = 1'b1;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timeout) begin
                    state_next = S_TRAP;
                    set_trap   = 1'b1;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    // Datapath controls, decoded from the current state and opcode; forced idle during reset
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        imm_sel   = 3'd0;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        alu_op    = 2'd0;
        wb_sel    = 2'd0;
        reg_write = 1'b0;
        state_o   = 3'd0;
        if (!reset) begin
            state_o = state;
            if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) imm_sel = decode_imm(opcode);
            case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXEC: begin
                    case (opcode)
                        OPC_OP:     alu_op = 2'd2;
                        OPC_OPIMM: begin
                            alu_src_b = 1'b1;
                            alu_op    = 2'd2;
                        end
                        OPC_LOAD, OPC_STORE: alu_src_b = 1'b1;
                        OPC_BRANCH: begin
                            alu_op   = 2'd1;
                            pc_write = branch_taken;
                            pc_src   = 2'd1;
                        end
                        OPC_LUI: begin
                            alu_src_a = 2'd2;
                            alu_src_b = 1'b1;
                        end
                        OPC_AUIPC: begin
                            alu_src_a = 2'd1;
                            alu_src_b = 1'b1;
                        end
                        OPC_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd1;
                        end
                        OPC_JALR: begin
                            alu_src_b = 1'b1;
                            pc_write  = 1'b1;
                            pc_src    = 2'd2;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (opcode == OPC_STORE);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (opcode == OPC_LOAD)                          wb_sel = 2'd1;
                    else if (opcode == OPC_JAL || opcode == OPC_JALR) wb_sel = 2'd2;
                end
                default: ;
            endcase
        end
    end

    // Memory wait counter: restarts on every state change, counts stalled request cycles
    always_ff @(posedge clk) begin
        if (reset)                        wait_cnt <= 32'd0;
        else if (state_next != state)     wait_cnt <= 32'd0;
        else if (mem_req && !mem_ready)   wait_cnt <= wait_cnt + 32'd1;
    end

    // Retired-instruction counter and sticky trap status
    always_ff @(posedge clk) begin
        if (reset) begin
            instret    <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
        end else begin
            if (retire) instret <= instret + CNT_W'(1);
            if (set_trap) begin
                trap       <= 1'b1;
                trap_cause <= cause_next;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-cycle vector table (inputs plus expected
// outputs) driven through a scoreboard queue and checked on the falling edge.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    localparam logic [31:0] ADDI  = 32'h00500093;
    localparam logic [31:0] LW    = 32'h00002103;
    localparam logic [31:0] SW    = 32'h00102023;
    localparam logic [31:0] BEQ   = 32'h00000063;
    localparam logic [31:0] JALR  = 32'h000080E7;
    localparam logic [31:0] JAL   = 32'h0000006F;
    localparam logic [31:0] LUI   = 32'h000010B7;
    localparam logic [31:0] AUIPC = 32'h00001097;
    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] ILL   = 32'h0000007F;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic [2:0] imm;
        logic [1:0] a;
        logic       b;
        logic [1:0] aop;
        logic [1:0] wb;
        logic       rw;
        logic       tr;
        logic [1:0] cs;
        logic [3:0] ir;
    } out_t;

    typedef struct {
        logic [63:0] tag;
        logic        rst;
        logic [31:0] ins;
        logic        rdy;
        logic        bt;
        out_t        exp;
        out_t        mask;
    } vec_t;

    logic             clk;
    logic             reset;
    logic [31:0]      instr;
    logic             mem_ready;
    logic             branch_taken;
    logic             mem_req, mem_we, ir_write, pc_write, alu_src_b, reg_write, trap;
    logic [1:0]       pc_src, alu_src_a, alu_op, wb_sel, trap_cause;
    logic [2:0]       imm_sel, state_o;
    logic [CNT_W-1:0] instret;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .imm_sel(imm_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .wb_sel(wb_sel),
        .reg_write(reg_write), .trap(trap), .trap_cause(trap_cause), .state_o(state_o),
        .instret(instret)
    );

    out_t obs;
    assign obs = {state_o, mem_req, mem_we, ir_write, pc_write, pc_src, imm_sel,
                  alu_src_a, alu_src_b, alu_op, wb_sel, reg_write, trap, trap_cause, instret};

    vec_t vecs[$];
    vec_t sb[$];
    vec_t cur;
    int   n_vec = 0;
    int   n_err = 0;
    out_t M_ALL;
    out_t M_RST;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors, want %0d", n_vec, vecs.size());
        $fatal(1);
    end

    function automatic out_t E(input int st, input int req, input int we, input int irw,
                               input int pcw, input int pcs, input int imm, input int a,
                               input int b, input int aop, input int wb, input int rw,
                               input int tr, input int cs, input int ir);
        out_t e;
        e.st  = 3'(st);  e.req = 1'(req); e.we  = 1'(we);  e.irw = 1'(irw);
        e.pcw = 1'(pcw); e.pcs = 2'(pcs); e.imm = 3'(imm); e.a   = 2'(a);
        e.b   = 1'(b);   e.aop = 2'(aop); e.wb  = 2'(wb);  e.rw  = 1'(rw);
        e.tr  = 1'(tr);  e.cs  = 2'(cs);  e.ir  = 4'(ir);
        return e;
    endfunction

    // FETCH with and without mem_ready, idle outputs otherwise
    function automatic out_t F_HIT(input int ir);
        return E(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir);
    endfunction
    function automatic out_t F_WAIT(input int ir);
        return E(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir);
    endfunction
    function automatic out_t IDLE0();
        return E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic add_m(input logic [63:0] tag, input logic rst, input logic [31:0] ins,
                         input logic rdy, input logic bt, input out_t e, input out_t m);
        vec_t v;
        v.tag = tag; v.rst = rst; v.ins = ins; v.rdy = rdy; v.bt = bt; v.exp = e; v.mask = m;
        vecs.push_back(v);
    endtask

    task automatic add(input logic [63:0] tag, input logic rst, input logic [31:0] ins,
                       input logic rdy, input logic bt, input out_t e);
        add_m(tag, rst, ins, rdy, bt, e, M_ALL);
    endtask

    // Checker: one expected record retires per falling edge
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            n_vec++;
            if (((obs ^ cur.exp) & cur.mask) !== '0) begin
                n_err++;
                $display("FAIL %s vec%0d: got %h want %h (mask %h) state_o=%0d instret=%0d",
                         cur.tag, n_vec - 1, obs, cur.exp, cur.mask, state_o, instret);
            end
        end
    end

    initial begin
        reset = 1'b1; instr = 32'h0; mem_ready = 1'b0; branch_taken = 1'b0;
        M_ALL = '1;
        M_RST = '1; M_RST.tr = 1'b0; M_RST.cs = 2'd0; M_RST.ir = 4'd0;

        // ---- reset: strobes gated even with mem_ready high ----
        add_m("RST0", 1, ADDI, 1, 0, IDLE0(), M_RST);
        add  ("RST1", 1, ADDI, 1, 1, IDLE0());
        // ---- ADDI, immediate fetch ----
        add("ADDI", 0, ADDI, 1, 0, F_HIT(0));
        add("ADDI", 0, ADDI, 0, 0, E(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("ADDI", 0, ADDI, 0, 0, E(2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
        add("ADDI", 0, ADDI, 0, 0, E(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // ---- LW, memory ready after 3 wait cycles ----
        add("LW", 0, LW, 1, 0, F_HIT(1));
        add("LW", 0, LW, 0, 0, E(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("LW", 0, LW, 0, 0, E(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++) add("LWMEM", 0, LW, 0, 0, E(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("LWMEM", 0, LW, 1, 0, E(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("LWWB",  0, LW, 0, 0, E(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        // ---- SW, retires straight from MEM ----
        add("SW", 0, SW, 1, 0, F_HIT(2));
        add("SW", 0, SW, 0, 0, E(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        add("SW", 0, SW, 0, 0, E(2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2));
        for (int k = 0; k < 3; k++) add("SWMEM", 0, SW, 0, 0, E(3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        add("SWMEM", 0, SW, 1, 0, E(3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        // ---- BEQ taken / not taken ----
        add("BEQT", 0, BEQ, 1, 0, F_HIT(3));
        add("BEQT", 0, BEQ, 0, 0, E(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 3));
        add("BEQT", 0, BEQ, 0, 1, E(2, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0, 0, 0, 0, 3));
        add("BEQN", 0, BEQ, 1, 1, F_HIT(4));
        add("BEQN", 0, BEQ, 0, 1, E(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 4));
        add("BEQN", 0, BEQ, 0, 0, E(2, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 4));
        // ---- JALR / JAL ----
        add("JALR", 0, JALR, 1, 0, F_HIT(5));
        add("JALR", 0, JALR, 0, 0, E(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        add("JALR", 0, JALR, 0, 0, E(2, 0, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 5));
        add("JALR", 0, JALR, 0, 0, E(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 5));
        add("JAL",  0, JAL,  1, 0, F_HIT(6));
        add("JAL",  0, JAL,  0, 0, E(1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 6));
        add("JAL",  0, JAL,  0, 0, E(2, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 6));
        add("JAL",  0, JAL,  0, 0, E(4, 0, 0, 0, 0, 0, 4, 0, 0, 0, 2, 1, 0, 0, 6));
        // ---- LUI / AUIPC / OP ----
        add("LUI",   0, LUI,   1, 0, F_HIT(7));
        add("LUI",   0, LUI,   0, 0, E(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 7));
        add("LUI",   0, LUI,   0, 0, E(2, 0, 0, 0, 0, 0, 3, 2, 1, 0, 0, 0, 0, 0, 7));
        add("LUI",   0, LUI,   0, 0, E(4, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 7));
        add("AUIPC", 0, AUIPC, 1, 0, F_HIT(8));
        add("AUIPC", 0, AUIPC, 0, 0, E(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 8));
        add("AUIPC", 0, AUIPC, 0, 0, E(2, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 8));
        add("AUIPC", 0, AUIPC, 0, 0, E(4, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 8));
        add("ADD",   0, ADD,   1, 0, F_HIT(9));
        add("ADD",   0, ADD,   0, 0, E(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9));
        add("ADD",   0, ADD,   0, 0, E(2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 9));
        add("ADD",   0, ADD,   0, 0, E(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9));

        // ---- illegal opcode: trap holds for 20 cycles whatever the inputs ----
        add("ILL", 0, ILL, 1, 0, F_HIT(10));
        add("ILL", 0, ILL, 1, 1, E(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10));
        for (int k = 0; k < 20; k++)
            add("ILLTRAP", 0, ILL, 1'(k), 1'(k >> 1), E(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 10));
        add_m("ILLRST", 1, ILL, 1, 1, IDLE0(), M_RST);

        // ---- fetch timeout after 4 unanswered request cycles ----
        for (int k = 0; k < 4; k++) add("FTMO", 0, ADDI, 0, 0, F_WAIT(0));
        add("FTMOTRAP", 0, ADDI, 1, 0, E(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0));
        add("FTMOTRAP", 0, ADDI, 0, 0, E(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0));
        add_m("FTMORST", 1, ADDI, 0, 0, IDLE0(), M_RST);

        // ---- ready in the limit cycle completes the fetch normally ----
        for (int k = 0; k < 3; k++) add("FLIM", 0, ADDI, 0, 0, F_WAIT(0));
        add("FLIM", 0, ADDI, 1, 0, F_HIT(0));
        add("FLIM", 0, ADDI, 0, 0, E(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("FLIM", 0, ADDI, 0, 0, E(2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
        add("FLIM", 0, ADDI, 0, 0, E(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

        // ---- reset while MEM holds mem_req high ----
        add("MRST", 0, LW, 1, 0, F_HIT(1));
        add("MRST", 0, LW, 0, 0, E(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("MRST", 0, LW, 0, 0, E(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        add("MRST", 0, LW, 0, 0, E(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add_m("MRST", 1, LW, 1, 0, IDLE0(), M_RST);
        add("MRSTF", 0, LW, 0, 0, F_WAIT(0));

        // ---- 16 retirements wrap the 4-bit counter back to zero ----
        for (int k = 0; k < 16; k++) begin
            add("WRAP", 0, ADDI, 1, 0, F_HIT(k));
            add("WRAP", 0, ADDI, 0, 0, E(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, k));
            add("WRAP", 0, ADDI, 0, 0, E(2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, k));
            add("WRAP", 0, ADDI, 0, 0, E(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, k));
        end

        // ---- store never acknowledged in MEM times out ----
        add("MTMO", 0, SW, 1, 0, F_HIT(0));
        add("MTMO", 0, SW, 0, 0, E(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add("MTMO", 0, SW, 0, 0, E(2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) add("MTMO", 0, SW, 0, 0, E(3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add("MTMOTRAP", 0, SW, 1, 0, E(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0));

        // ---- apply: drive after the rising edge, checker compares on the falling edge ----
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            reset        = vecs[i].rst;
            instr        = vecs[i].ins;
            mem_ready    = vecs[i].rdy;
            branch_taken = vecs[i].bt;
            sb.push_back(vecs[i]);
        end
        @(negedge clk);
        #1;
        if (sb.size() != 0 || n_vec != vecs.size()) begin
            n_err++;
            $display("FAIL drain: got %0d checked, want %0d", n_vec, vecs.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
